// File: rtl/param_serializer.sv
// Parallel-to-serial shifter for the UART TX path: one bit per ser_en tick, optional parity slot.
// ser_done marks the LAST cycle, in which a new word can be loaded so frames run back-to-back.
module param_serializer #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ser_en,
  output logic              ser_out,
  output logic              ser_done,
  output logic              busy,
  output logic              par_bit
);

  localparam int N  = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_SLOT   = CW'(N - 1);
  localparam logic [CW-1:0] PARITY_SLOT = CW'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LAST
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              ser_out_q, ser_out_d;
  logic              par_bit_q, par_bit_d;
  logic              accept;

  assign in_ready = (state_q != S_SHIFT);
  assign busy     = (state_q != S_IDLE);
  assign ser_done = (state_q == S_LAST);
  assign ser_out  = ser_out_q;
  assign par_bit  = par_bit_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    ser_out_d = ser_out_q;
    par_bit_d = par_bit_q;

    case (state_q)
      S_SHIFT: begin
        if (ser_en) begin
          // The parity slot follows the data bits; the shift register is already drained by then.
          if ((PARITY_EN != 0) && (cnt_q == PARITY_SLOT)) begin
            ser_out_d = par_bit_q;
          end else if (MSB_FIRST != 0) begin
            ser_out_d = shreg_q[DATA_W-1];
            shreg_d   = shreg_q << 1;
          end else begin
            ser_out_d = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
          if (cnt_q == LAST_SLOT) begin
            state_d = S_LAST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_LAST: begin
        if (!accept) begin
          state_d   = S_IDLE;
          ser_out_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d   = S_SHIFT;
      cnt_d     = '0;
      shreg_d   = in_data;
      ser_out_d = 1'b0;
      par_bit_d = (^in_data) ^ (PARITY_ODD != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      ser_out_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      ser_out_q <= ser_out_d;
      par_bit_q <= par_bit_d;
    end
  end

endmodule

// File: tb/tb_param_serializer.sv
// Four serializer configurations driven by shared stimulus, checked against a slot-list reference model.
module tb_param_serializer;

  localparam int NI = 4;
  localparam int P_MSB [NI] = '{0, 1, 0, 0};
  localparam int P_PEN [NI] = '{0, 0, 1, 1};
  localparam int P_ODD [NI] = '{0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       ser_en;
  logic       ir [NI];
  logic       so [NI];
  logic       sd [NI];
  logic       bz [NI];
  logic       pb [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    param_serializer #(
      .DATA_W    (8),
      .MSB_FIRST (P_MSB[g]),
      .PARITY_EN (P_PEN[g]),
      .PARITY_ODD(P_ODD[g])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(ir[g]),
      .ser_en  (ser_en),
      .ser_out (so[g]),
      .ser_done(sd[g]),
      .busy    (bz[g]),
      .par_bit (pb[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a loaded word is a list of N slots; 'sent' counts how many reached the line.
  logic       m_loaded [NI];
  int         m_sent   [NI];
  logic [7:0] m_word   [NI];
  logic       m_out    [NI];
  logic       m_par    [NI];

  function automatic logic slot_bit(int i, logic [7:0] w, int k, logic p);
    if (k >= 8) return p;
    return (P_MSB[i] != 0) ? w[7 - k] : w[k];
  endfunction

  function automatic int n_slots(int i);
    return 8 + P_PEN[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      logic done, rdy;
      done = m_loaded[i] && (m_sent[i] == n_slots(i));
      rdy  = !m_loaded[i] || done;
      if (rst) begin
        m_loaded[i] = 1'b0; m_sent[i] = 0; m_word[i] = '0; m_out[i] = 1'b0; m_par[i] = 1'b0;
      end else if (in_valid && rdy) begin
        m_loaded[i] = 1'b1; m_sent[i] = 0; m_word[i] = in_data; m_out[i] = 1'b0;
        m_par[i] = ($countones(in_data) % 2 == 1) ^ (P_ODD[i] != 0);
      end else if (done) begin
        m_loaded[i] = 1'b0; m_sent[i] = 0; m_out[i] = 1'b0;
      end else if (m_loaded[i] && ser_en) begin
        m_out[i] = slot_bit(i, m_word[i], m_sent[i], m_par[i]);
        m_sent[i]++;
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      logic done;
      done = m_loaded[i] && (m_sent[i] == n_slots(i));
      chk($sformatf("u%0d.ser_out", i), so[i], m_out[i]);
      chk($sformatf("u%0d.ser_done", i), sd[i], done);
      chk($sformatf("u%0d.busy", i), bz[i], m_loaded[i]);
      chk($sformatf("u%0d.in_ready", i), ir[i], !m_loaded[i] || done);
      chk($sformatf("u%0d.par_bit", i), pb[i], m_par[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; ser_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] w);
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d2, w7;
    d2 = 8'hD2;
    w7 = 8'h07;
    rst = 1'b1; in_valid = 1'b0; ser_en = 1'b0; in_data = '0;

    // Reset values
    do_reset();
    for (int i = 0; i < NI; i++) begin
      chk("rst_out", so[i], 1'b0); chk("rst_done", sd[i], 1'b0);
      chk("rst_busy", bz[i], 1'b0); chk("rst_ready", ir[i], 1'b1); chk("rst_par", pb[i], 1'b0);
    end

    // 0xD2 LSB-first and MSB-first
    load(d2);
    chk("load_ready", ir[0], 1'b0);
    chk("load_busy", bz[0], 1'b1);
    ser_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("lsb_bit", so[0], d2[k]);
      chk("msb_bit", so[1], d2[7 - k]);
      chk("lsb_done", sd[0], k == 7);
      chk("msb_done", sd[1], k == 7);
    end
    ser_en = 1'b0;
    tick();
    chk("idle_out", so[0], 1'b0);
    chk("idle_busy", bz[0], 1'b0);

    // Parity even/odd on 0x07
    do_reset();
    load(w7);
    chk("par_even", pb[2], 1'b1);
    chk("par_odd", pb[3], 1'b0);
    ser_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("even_bit", so[2], (k < 8) ? w7[k] : 1'b1);
      chk("odd_bit", so[3], (k < 8) ? w7[k] : 1'b0);
      chk("even_done", sd[2], k == 8);
      chk("odd_done", sd[3], k == 8);
    end
    ser_en = 1'b0;

    // Stall after bit 3
    do_reset();
    load(d2);
    ser_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pre", so[0], d2[k]);
    end
    ser_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_hold", so[0], 1'b0);
      chk("stall_done", sd[0], 1'b0);
    end
    ser_en = 1'b1;
    for (int k = 3; k < 8; k++) begin
      tick();
      chk("stall_post", so[0], d2[k]);
      chk("stall_pdone", sd[0], k == 7);
    end
    ser_en = 1'b0;

    // Back-to-back with in_valid held
    do_reset();
    in_valid = 1'b1; in_data = d2;
    tick();
    in_data = w7;
    ser_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b2b_w1_bit", so[0], d2[k]);
      chk("b2b_ready", ir[0], k == 7);
      chk("b2b_done", sd[0], k == 7);
    end
    tick();
    chk("b2b_busy", bz[0], 1'b1);
    chk("b2b_nodone", sd[0], 1'b0);
    chk("b2b_ready2", ir[0], 1'b0);
    chk("b2b_out0", so[0], 1'b0);
    chk("b2b_par", pb[0], 1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b2b_w2_bit", so[0], w7[k]);
      chk("b2b_w2_done", sd[0], k == 7);
    end
    ser_en = 1'b0;
    tick();

    // Reset mid-word, then a fresh word
    do_reset();
    load(d2);
    ser_en = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ser_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("mid_out", so[i], 1'b0); chk("mid_done", sd[i], 1'b0);
      chk("mid_busy", bz[i], 1'b0); chk("mid_ready", ir[i], 1'b1); chk("mid_par", pb[i], 1'b0);
    end
    load(w7);
    ser_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fresh_bit", so[0], w7[k]);
      chk("fresh_done", sd[0], k == 7);
    end
    ser_en = 1'b0;

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      ser_en   = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_serializer.md
# param_serializer

Parametrised parallel-to-serial shifter for the UART transmit path. It accepts a DATA_W-bit word over a valid/ready handshake and emits one bit per `ser_en` cycle, LSB- or MSB-first. It optionally appends a parity bit and pulses `ser_done` while the final bit is on the line. It sits between the TX holding logic and the TX frame FSM/output mux, which owns start and stop bits.

## Interface
- `DATA_W`, default 8: word width, valid range 1–32.
- `MSB_FIRST`, default 0: 0 sends bit 0 first; 1 sends bit DATA_W-1 first.
- `PARITY_EN`, default 0: 1 appends one parity bit after the data bits.
- `PARITY_ODD`, default 0: parity sense, used only when PARITY_EN=1. 0 = even, 1 = odd.

- `clk` input, 1 bit: the only clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset; it overrides every other input.
- `in_data` input, DATA_W bits: word to send; sampled only on acceptance.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: the block can accept a word this cycle.
- `ser_en` input, 1 bit: advance one bit (baud tick from the TX FSM).
- `ser_out` output, 1 bit: serial data, registered.
- `ser_done` output, 1 bit: high while the final bit of the frame is on `ser_out`.
- `busy` output, 1 bit: a word is loaded and not yet completed.
- `par_bit` output, 1 bit: parity of the currently loaded word, registered at load.

## Operation
- N = DATA_W + PARITY_EN bit slots per word. Bit counter width is clog2(N+1).
- States:
  - IDLE: `in_ready`=1, `busy`=0, `ser_done`=0.
  - SHIFT: `in_ready`=0, `busy`=1.
  - LAST: `in_ready`=1, `busy`=1, `ser_done`=1.
- Acceptance: `in_valid` && `in_ready` at a rising edge.
  - Capture `in_data` into the shift register and capture `par_bit` = ^`in_data` ^ PARITY_ODD.
  - Set counter to 0, drive `ser_out` to 0, enter SHIFT.
- IDLE without acceptance: hold. `ser_en` is ignored.
- SHIFT with `ser_en`=1 at an edge:
  - `ser_out` takes the next slot: data bits in configured order, then parity if PARITY_EN=1. Counter increments.
  - When the slot driven is slot N-1, enter LAST and clear the counter.
- SHIFT with `ser_en`=0: hold `ser_out`, counter and shift register (stall of any length).
- LAST: `ser_done` is decoded from state and lasts exactly one cycle.
  - Next edge with acceptance: load the new word and enter SHIFT, giving zero-gap back-to-back.
  - Next edge without acceptance: go to IDLE and drive `ser_out` to 0.
  - `ser_en` is ignored in LAST.
- `in_valid` while in SHIFT is ignored and the word is not captured. The source must hold it until `in_ready`.
- A `ser_en` edge and an acceptance edge never coincide: acceptance occurs only in IDLE/LAST, where `ser_en` is ignored.

## Timing
- Reset, applied at the edge where `rst`=1 in any state, mid-word included:
  - state = IDLE, counter = 0, shift register = 0.
  - `ser_out`=0, `par_bit`=0, `ser_done`=0, `busy`=0, `in_ready`=1 from the following cycle.
  - The in-flight word is discarded with no `ser_done`.
- Latency: the first bit appears on `ser_out` one cycle after the first `ser_en` edge following acceptance.
- Each subsequent bit appears one cycle after each further `ser_en` edge.
- `ser_done` rises in the same cycle the final bit appears on `ser_out`.
- Throughput: N `ser_en` edges plus one LAST cycle per word. A back-to-back load is accepted on the LAST→SHIFT edge.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs, except none: `in_ready` is a state decode.

## Test plan
- DATA_W=8, MSB_FIRST=0, PARITY_EN=0: load 0xD2, pulse `ser_en` on 8 consecutive cycles.
  - `ser_out` = 0,1,0,0,1,0,1,1.
  - `ser_done`=1 only on the 8th bit cycle, then IDLE with `ser_out`=0.
- Same word with MSB_FIRST=1: `ser_out` = 1,1,0,1,0,0,1,0; `ser_done` on the 8th bit.
- PARITY_EN=1, PARITY_ODD=0: load 0x07.
  - Bits 1,1,1,0,0,0,0,0, then parity 1.
  - `ser_done` on the 9th bit; `par_bit`=1 from the load edge.
  - Repeat with PARITY_ODD=1: parity bit 0.
- Stall: load 0xD2 and drop `ser_en` for 5 cycles after bit 3. `ser_out` holds 0 for those 5 cycles and the remaining sequence is unchanged.
- Back-to-back: hold `in_valid`=1 with 0xD2 then 0x07.
  - `in_ready` is 0 during SHIFT and 1 in the LAST cycle of word 1.
  - Word 2 is loaded on that edge with no IDLE cycle.
  - A word presented mid-SHIFT is not captured.
- Reset mid-word: assert `rst` after bit 4 of 0xD2.
  - Next cycle: all outputs at reset values, no `ser_done`.
  - A fresh load of 0x07 then serialises correctly.
